// File: rtl/timebase_divider_pkg.sv
// timebase_pkg: shared constants and ratio clamp for the timebase divider.
//   CNT_W_DEF - default counter/ratio width
//   MIN_DIV   - smallest usable divide ratio
//   clamp_div - maps ratios below MIN_DIV up to MIN_DIV
package timebase_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int MIN_DIV = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < 32'(MIN_DIV)) ? 32'(MIN_DIV) : n;
    endfunction
endpackage

// File: rtl/timebase_divider_sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser followed by a rising-edge pulse.
//   clk     - sampling clock
//   rst     - asynchronous active-high reset
//   async_i - asynchronous trigger input
//   pulse_o - one-cycle pulse per synchronised rising edge
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic pulse_o
);
    // [1:0] is the synchroniser, [2] holds the previous synchronised value.
    logic [2:0] sh_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) sh_q <= '0;
        else     sh_q <= {sh_q[1:0], async_i};

    assign pulse_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/timebase_divider.sv
// timebase_divider: programmable clock divider with glitch-free ratio reload.
//   clk, rst   - clock and asynchronous active-high reset
//   en         - count enable, low freezes the divider
//   div_ratio  - requested ratio N, captured by the load strobe
//   load       - one-cycle strobe capturing div_ratio as pending ratio
//   sync_in    - (only with TIMEBASE_SYNC_EN) async trigger restarting the period
//   outclk     - divided clock: low ceil(N/2) cycles, high floor(N/2)
//   tick       - one pulse per output period, in the last cycle of the period
//   ld_ack     - one-cycle pulse after a pending ratio became active
module timebase_divider
    import timebase_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             load,
`ifdef TIMEBASE_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             outclk,
    output logic             tick,
    output logic             ld_ack
);
    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(clamp_div(32'(DEF_DIV)));

    logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d, ld_n, half_d;
    logic             pv_q, pv_d, out_q, tick_q, ack_q;
    logic             force_c, wrap, apply, sync_pulse;

`ifdef TIMEBASE_SYNC_EN
    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (sync_in),
        .pulse_o (sync_pulse)
    );
`else
    assign sync_pulse = 1'b0;
`endif

    always_comb begin
        ld_n    = CNT_W'(clamp_div(32'(div_ratio)));
        // A restart (sync edge or load while frozen) beats wrap and enable.
        force_c = sync_pulse | (load & ~en);
        wrap    = en & (cnt_q == act_q - CNT_W'(1)) & ~force_c;
        // On a wrap only the previously pending ratio is applied; a load in
        // the wrap cycle becomes the new pending ratio for the next wrap.
        apply   = force_c ? (load | pv_q) : (wrap & pv_q);
        act_d   = !apply ? act_q : (force_c & load) ? ld_n : pend_q;
        pv_d    = (load & ~force_c) | (pv_q & ~apply);
        pend_d  = (load & ~force_c) ? ld_n : pend_q;
        cnt_d   = (force_c | wrap) ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
        // ceil(N/2) without needing an extra bit for N at full scale.
        half_d  = (act_d >> 1) + CNT_W'(act_d[0]);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt_q  <= '0;
            act_q  <= DEF_N;
            pend_q <= DEF_N;
            pv_q   <= 1'b0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            pv_q   <= pv_d;
            out_q  <= cnt_d >= half_d;
            tick_q <= cnt_d == act_d - CNT_W'(1);
            ack_q  <= apply;
        end

    assign outclk = out_q;
    // Gated by en so a frozen divider never reports a tick.
    assign tick   = tick_q & en;
    assign ld_ack = ack_q;
endmodule

// File: tb/tb_timebase_divider.sv
// tb_timebase_divider: randomized and directed self-checking bench for timebase_divider.
module tb_timebase_divider;
    localparam int DEF = 4;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0;
    logic [15:0] div_ratio = '0;
    logic        outclk, tick, ld_ack;
`ifdef TIMEBASE_SYNC_EN
    logic        sync_in = 1'b0;
`endif

    int checks = 0, errors = 0;
    // Reference model: active period length, position in period, pending ratio.
    int n = DEF, pos = 0, pend = 0, scd = 0;
    bit pv = 0, ack = 0;

    always #5 clk = ~clk;

    timebase_divider #(.CNT_W(16), .DEF_DIV(DEF)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_ratio (div_ratio),
        .load      (load),
`ifdef TIMEBASE_SYNC_EN
        .sync_in   (sync_in),
`endif
        .outclk    (outclk),
        .tick      (tick),
        .ld_ack    (ld_ack)
    );

    task automatic chk(string tag, logic got, logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b (n=%0d pos=%0d)", tag, got, exp, n, pos);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".outclk"}, outclk, 2 * pos >= n);
        chk({tag, ".tick"}, tick, en && pos == n - 1);
        chk({tag, ".ld_ack"}, ld_ack, ack);
    endtask

    task automatic cyc(string tag, bit e, bit l, int d);
        int cd = (d < 2) ? 2 : d;
        bit frc;
        en = e;
        load = l;
        div_ratio = 16'(d);
        @(posedge clk);
        frc = l && !e;
        if (scd > 0) begin
            scd--;
            if (scd == 0) frc = 1;
        end
        ack = 0;
        if (frc) begin
            pos = 0;
            if (l) begin
                n = cd;
                ack = 1;
            end else if (pv) begin
                n = pend;
                ack = 1;
            end
            pv = 0;
        end else if (e) begin
            if (pos == n - 1) begin
                pos = 0;
                if (pv) begin
                    n = pend;
                    ack = 1;
                end
                pv = 0;
            end else pos++;
            if (l) begin
                pend = cd;
                pv = 1;
            end
        end
        #1 check_all(tag);
    endtask

    task automatic run_to(string tag, int p);
        for (int i = 0; i < 200 && pos != p; i++) cyc(tag, 1, 0, 0);
        if (pos != p) begin
            errors++;
            $error("FAIL %s.run_to: position %0d never reached, at %0d", tag, p, pos);
        end
    endtask

    task automatic do_reset(string tag);
        #2 rst = 1'b1;
        #1;
        n = DEF;
        pos = 0;
        pv = 0;
        ack = 0;
        scd = 0;
        check_all(tag);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        do_reset("reset");
        repeat (12) cyc("def4", 1, 0, 0);
        run_to("ld5", 1);
        cyc("ld5", 1, 1, 5);
        repeat (14) cyc("ld5", 1, 0, 0);
        cyc("ld0", 1, 1, 0);
        repeat (6) cyc("ld0", 1, 0, 0);
        cyc("ld1", 1, 1, 1);
        repeat (8) cyc("ld1", 1, 0, 0);
        cyc("frz", 0, 1, 6);
        run_to("frz", 2);
        repeat (7) cyc("frz", 0, 0, 0);
        repeat (9) cyc("frz", 1, 0, 0);
        cyc("dbl", 0, 1, 10);
        cyc("dbl", 1, 1, 8);
        repeat (3) cyc("dbl", 1, 0, 0);
        cyc("dbl", 1, 1, 3);
        repeat (16) cyc("dbl", 1, 0, 0);
        run_to("wrapld", 2);
        cyc("wrapld", 1, 1, 7);
        repeat (10) cyc("wrapld", 1, 0, 0);
        run_to("midrst", 3);
        cyc("midrst", 1, 1, 9);
        do_reset("midrst");
        repeat (10) cyc("postrst", 1, 0, 0);
        for (int i = 0; i < 400; i++)
            cyc("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 12)));
`ifdef TIMEBASE_SYNC_EN
        cyc("sync", 0, 1, 9);
        run_to("sync", 4);
        cyc("sync", 1, 1, 4);
        sync_in = 1'b1;
        scd = 3;
        repeat (10) cyc("sync", 1, 0, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
